// File: rtl/uart_mmio_bridge.sv
// CPU load/store front end for the UART transceiver: TX/RX byte FIFOs behind three word registers.
// Optional RX interrupt output is compiled in with `define UART_BRIDGE_IRQ_EN.
module uart_mmio_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h40000018,
   parameter int          TX_DEPTH  = 4,
   parameter int          RX_DEPTH  = 4
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        irq,
   output logic [7:0]  uart_txd,
   output logic [4:0]  uart_con,
   input  logic [7:0]  uart_rxd,
   input  logic [4:0]  uart_conout
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_ONE = 1;
   localparam logic [RX_AW:0] RX_ONE = 1;

   logic sel_tx, sel_rx, sel_ctl;
   logic tx_push, tx_pop, tx_empty, tx_full, tx_idle;
   logic rx_push, rx_accept, rx_pop, rx_empty, rx_full, ovr_set;
   logic ctl_wr, st_rd, irq_en;
   logic [7:0] rx_head;

   logic [7:0]     tx_mem_q [TX_DEPTH];
   logic [TX_AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [7:0]     rx_mem_q [RX_DEPTH];
   logic [RX_AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;

   logic busy_q;
   logic rxv_s1_q, rxv_s2_q, rxv_s3_q;
   logic overrun_q, overrun_d;
   logic rx_en_q, rx_en_d;

   logic unused_bits;
   assign unused_bits = ^{wdata[31:8], wdata[1], uart_conout[2:0]};

   // ---------------------------------------------------------------- address decode
   assign sel_tx  = addr == BASE_ADDR;
   assign sel_rx  = addr == BASE_ADDR + 32'd4;
   assign sel_ctl = addr == BASE_ADDR + 32'd8;
   assign hit     = sel_tx | sel_rx | sel_ctl;
   assign ctl_wr  = mem_write & sel_ctl;
   assign st_rd   = mem_read & sel_ctl;

   // ---------------------------------------------------------------- TX FIFO
   assign tx_empty = tx_wp_q == tx_rp_q;
   assign tx_full  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) &&
                     (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
   // A busy rising edge means the transceiver has just latched the head byte.
   assign tx_pop   = uart_conout[4] & ~busy_q & ~tx_empty;
   assign tx_push  = mem_write & sel_tx & (~tx_full | tx_pop);
   assign tx_idle  = tx_empty & ~uart_conout[4];

   always_comb begin
      tx_wp_d = tx_wp_q;
      tx_rp_d = tx_rp_q;
      if (tx_push) tx_wp_d = tx_wp_q + TX_ONE;
      if (tx_pop)  tx_rp_d = tx_rp_q + TX_ONE;
   end

   always_ff @(posedge sysclk) begin
      if (tx_push) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= wdata[7:0];
   end

   assign uart_txd = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q[TX_AW-1:0]];

   // ---------------------------------------------------------------- RX FIFO
   assign rx_empty  = rx_wp_q == rx_rp_q;
   assign rx_full   = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) &&
                      (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);
   assign rx_push   = rxv_s2_q & ~rxv_s3_q;
   assign rx_pop    = mem_read & sel_rx & ~rx_empty;
   assign rx_accept = rx_push & (~rx_full | rx_pop);
   assign ovr_set   = rx_push & rx_full & ~rx_pop;
   assign rx_head   = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[RX_AW-1:0]];

   always_comb begin
      rx_wp_d = rx_wp_q;
      rx_rp_d = rx_rp_q;
      if (rx_accept) rx_wp_d = rx_wp_q + RX_ONE;
      if (rx_pop)    rx_rp_d = rx_rp_q + RX_ONE;
   end

   always_ff @(posedge sysclk) begin
      if (rx_accept) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= uart_rxd;
   end

   // ---------------------------------------------------------------- control / status
   always_comb begin
      rx_en_d   = ctl_wr ? wdata[0] : rx_en_q;
      overrun_d = overrun_q;
      if (st_rd)   overrun_d = 1'b0;
      if (ovr_set) overrun_d = 1'b1;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tx_wp_q   <= '0;
         tx_rp_q   <= '0;
         rx_wp_q   <= '0;
         rx_rp_q   <= '0;
         busy_q    <= 1'b0;
         rxv_s1_q  <= 1'b0;
         rxv_s2_q  <= 1'b0;
         rxv_s3_q  <= 1'b0;
         overrun_q <= 1'b0;
         rx_en_q   <= 1'b0;
      end else begin
         tx_wp_q   <= tx_wp_d;
         tx_rp_q   <= tx_rp_d;
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         busy_q    <= uart_conout[4];
         rxv_s1_q  <= uart_conout[3];
         rxv_s2_q  <= rxv_s1_q;
         rxv_s3_q  <= rxv_s2_q;
         overrun_q <= overrun_d;
         rx_en_q   <= rx_en_d;
      end
   end

`ifdef UART_BRIDGE_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;

   always_comb begin
      irq_en_d = ctl_wr ? wdata[1] : irq_en_q;
      irq_d    = irq_en_q & ~rx_empty;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq_en = irq_en_q;
   assign irq    = irq_q;
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   // ---------------------------------------------------------------- outputs
   // Enable follows busy combinationally so it drops the same cycle busy falls on an empty FIFO.
   assign uart_con = {3'b000, rx_en_q, ~tx_empty | uart_conout[4]};

   always_comb begin
      rdata = 32'h0;
      if (mem_read) begin
         if (sel_rx)
            rdata = {24'h0, rx_head};
         else if (sel_ctl)
            rdata = {26'h0, irq_en, rx_en_q, overrun_q, tx_idle, tx_full, ~rx_empty};
      end
   end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed scenarios plus randomized transactions
// against a queue-based model of the register map.
module tb_uart_mmio_bridge;

   localparam logic [31:0] A_TX = 32'h40000018;
   localparam logic [31:0] A_RX = 32'h4000001C;
   localparam logic [31:0] A_ST = 32'h40000020;
`ifdef UART_BRIDGE_IRQ_EN
   localparam bit IRQB = 1'b1;
`else
   localparam bit IRQB = 1'b0;
`endif

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic        mem_read, mem_write, hit, irq;
   logic [7:0]  uart_txd, uart_rxd;
   logic [4:0]  uart_con, uart_conout;

   uart_mmio_bridge dut (
      .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata), .hit(hit),
      .irq(irq), .uart_txd(uart_txd), .uart_con(uart_con),
      .uart_rxd(uart_rxd), .uart_conout(uart_conout)
   );

   always #5 sysclk = ~sysclk;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   bit m_ovr, m_rxen, m_irqen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; mem_write = 1'b1;
      tick();
      mem_write = 1'b0; addr = 32'h0;
   endtask

   task automatic cpu_rd(input logic [31:0] a, output logic [31:0] d);
      addr = a; mem_read = 1'b1;
      #1 d = rdata;
      tick();
      mem_read = 1'b0; addr = 32'h0;
   endtask

   task automatic rx_byte(input logic [7:0] b, input int hold);
      uart_rxd = b; uart_conout[3] = 1'b1;
      repeat (hold) tick();
      uart_conout[3] = 1'b0;
      repeat (4) tick();
   endtask

   function automatic logic [31:0] exp_status();
      return {26'h0, IRQB & m_irqen, m_rxen, m_ovr, tx_q.size() == 0,
              tx_q.size() == 4, rx_q.size() != 0};
   endfunction

   function automatic logic [7:0] tx_head();
      return (tx_q.size() != 0) ? tx_q[0] : 8'h00;
   endfunction

   task automatic apply_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tx_q.delete(); rx_q.delete();
      m_ovr = 0; m_rxen = 0; m_irqen = 0;
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  seq [4];
      addr = 0; wdata = 0; mem_read = 0; mem_write = 0;
      uart_rxd = 0; uart_conout = 0; reset = 1'b0;
      tick();
      check("rst_con", uart_con, 0);
      check("rst_txd", uart_txd, 0);
      check("rst_irq", irq, 0);
      check("rst_rdata", rdata, 0);
      reset = 1'b1;
      tick();

      // Test 1: status after reset shows only tx_idle
      cpu_rd(A_ST, d);
      check("t1_status", d, 32'h4);
      cpu_rd(A_TX, d);
      check("t1_txdata_rd", d, 0);

      // Test 2: single byte through the TX path
      cpu_wr(A_TX, 32'hA5);
      check("t2_txd", uart_txd, 8'hA5);
      check("t2_txen", uart_con[0], 1);
      uart_conout[4] = 1'b1;
      tick();
      check("t2_en_busy", uart_con[0], 1);
      cpu_rd(A_ST, d);
      check("t2_status_busy", d, 32'h0);
      uart_conout[4] = 1'b0;
      #1 check("t2_en_drop", uart_con[0], 0);
      tick();

      // Test 3: fill TX while busy, overflow byte lost, drain in order
      uart_conout[4] = 1'b1;
      tick();
      cpu_wr(A_TX, 32'h11); cpu_wr(A_TX, 32'h22); cpu_wr(A_TX, 32'h33);
      cpu_wr(A_TX, 32'h44); cpu_wr(A_TX, 32'h55);
      cpu_rd(A_ST, d);
      check("t3_full", d, 32'h2);
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         uart_conout[4] = 1'b0;
         tick();
         check($sformatf("t3_txd%0d", i), uart_txd, seq[i]);
         uart_conout[4] = 1'b1;
         tick();
      end
      uart_conout[4] = 1'b0;
      #1 check("t3_en_drop", uart_con[0], 0);
      tick();

      // TX full: CPU push and busy-edge pop on the same edge
      cpu_wr(A_TX, 32'hD0); cpu_wr(A_TX, 32'hD1); cpu_wr(A_TX, 32'hD2); cpu_wr(A_TX, 32'hD3);
      addr = A_TX; wdata = 32'hD4; mem_write = 1'b1; uart_conout[4] = 1'b1;
      tick();
      mem_write = 1'b0; addr = 0;
      cpu_rd(A_ST, d);
      check("txsim_full", d, 32'h2);
      seq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
      for (int i = 0; i < 4; i++) begin
         uart_conout[4] = 1'b0;
         tick();
         check($sformatf("txsim_txd%0d", i), uart_txd, seq[i]);
         uart_conout[4] = 1'b1;
         tick();
      end
      uart_conout[4] = 1'b0;
      tick();
      check("txsim_empty_en", uart_con[0], 0);

      // Test 4: long rx-valid pulses push once each
      cpu_wr(A_ST, 32'h1);
      check("t4_rxen", uart_con, 5'b00010);
      rx_byte(8'h3C, 652);
      rx_byte(8'h7E, 652);
      cpu_rd(A_RX, d); check("t4_rx0", d, 32'h3C);
      cpu_rd(A_RX, d); check("t4_rx1", d, 32'h7E);
      cpu_rd(A_RX, d); check("t4_rx_empty", d, 32'h0);

      // Test 5: overrun on the fifth byte, overrun cleared by status read
      for (int i = 0; i < 5; i++) rx_byte(8'hA0 + 8'(i), 10);
      cpu_rd(A_ST, d); check("t5_ovr_set", d, 32'h1D);
      cpu_rd(A_ST, d); check("t5_ovr_clr", d, 32'h15);
      for (int i = 0; i < 4; i++) begin
         cpu_rd(A_RX, d);
         check($sformatf("t5_rx%0d", i), d, 32'hA0 + i);
      end
      cpu_rd(A_RX, d); check("t5_rx_empty", d, 0);

      // RX full: push and pop on the same edge, no overrun
      for (int i = 0; i < 4; i++) rx_byte(8'hB0 + 8'(i), 5);
      uart_rxd = 8'hB4; uart_conout[3] = 1'b1;
      tick(); tick();
      addr = A_RX; mem_read = 1'b1;
      #1 check("rxsim_head", rdata, 32'hB0);
      tick();
      mem_read = 1'b0; addr = 0; uart_conout[3] = 1'b0;
      repeat (4) tick();
      cpu_rd(A_ST, d); check("rxsim_status", d, 32'h15);
      for (int i = 1; i < 5; i++) begin
         cpu_rd(A_RX, d);
         check($sformatf("rxsim_rx%0d", i), d, 32'hB0 + i);
      end
      cpu_rd(A_RX, d); check("rxsim_empty", d, 0);

      // Overrun set and status-read clear on the same edge: set wins
      for (int i = 0; i < 4; i++) rx_byte(8'hC0 + 8'(i), 5);
      uart_rxd = 8'hC4; uart_conout[3] = 1'b1;
      tick(); tick();
      addr = A_ST; mem_read = 1'b1;
      #1 check("ovsim_pre", rdata, 32'h15);
      tick();
      mem_read = 1'b0; addr = 0; uart_conout[3] = 1'b0;
      repeat (4) tick();
      cpu_rd(A_ST, d); check("ovsim_set", d, 32'h1D);
      cpu_rd(A_ST, d); check("ovsim_clr", d, 32'h15);
      for (int i = 0; i < 4; i++) begin
         cpu_rd(A_RX, d);
         check($sformatf("ovsim_rx%0d", i), d, 32'hC0 + i);
      end

      // Test 6: interrupt follows rx_nonempty with one cycle lag
      cpu_wr(A_ST, 32'h3);
      uart_rxd = 8'h5A; uart_conout[3] = 1'b1;
      tick(); tick(); tick();
      check("t6_irq_lag", irq, 0);
      tick();
      check("t6_irq_set", irq, IRQB);
      uart_conout[3] = 1'b0;
      repeat (4) tick();
      cpu_rd(A_ST, d); check("t6_status", d, IRQB ? 32'h35 : 32'h15);
      cpu_rd(A_RX, d); check("t6_rx", d, 32'h5A);
      tick();
      check("t6_irq_clr", irq, 0);

      // Randomized transactions against the queue model
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         int unsigned r;
         logic [7:0]  b;
         logic [31:0] a, want;
         r = $urandom_range(0, 11);
         case (r)
            0, 1, 2: begin
               b = 8'($urandom);
               cpu_wr(A_TX, {24'($urandom), b});
               if (tx_q.size() < 4) tx_q.push_back(b);
            end
            3, 4: begin
               check("rnd_txd_pre", uart_txd, tx_head());
               uart_conout[4] = 1'b1;
               #1 check("rnd_en_busy", uart_con[0], 1);
               tick();
               if (tx_q.size() != 0) void'(tx_q.pop_front());
               repeat ($urandom_range(0, 5)) tick();
               uart_conout[4] = 1'b0;
               #1 check("rnd_en_fall", uart_con[0], tx_q.size() != 0);
               tick();
            end
            5, 6: begin
               if (m_rxen) begin
                  b = 8'($urandom);
                  rx_byte(b, $urandom_range(1, 20));
                  if (rx_q.size() < 4) rx_q.push_back(b);
                  else m_ovr = 1;
               end
            end
            7, 8: begin
               want = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
               cpu_rd(A_RX, d);
               check("rnd_rxdata", d, want);
            end
            9: begin
               want = exp_status();
               cpu_rd(A_ST, d);
               check("rnd_status", d, want);
               m_ovr = 0;
            end
            10: begin
               a = 32'($urandom_range(0, 3));
               if ($urandom_range(0, 3) != 0) a[0] = 1'b1;
               cpu_wr(A_ST, a | (32'($urandom) & 32'hFFFF_FFFC));
               m_rxen = a[0];
               m_irqen = a[1];
            end
            default: begin
               a = A_TX - 32'd8 + 32'($urandom_range(0, 24));
               addr = a;
               #1 check("rnd_hit", hit, (a == A_TX) || (a == A_RX) || (a == A_ST));
               addr = 0;
            end
         endcase
         tick(); tick();
         check("rnd_irq", irq, IRQB & m_irqen & (rx_q.size() != 0));
         check("rnd_con", uart_con, {3'b000, m_rxen, tx_q.size() != 0});
         check("rnd_txd", uart_txd, tx_head());
      end

      // Asynchronous reset mid-traffic flushes both FIFOs
      cpu_wr(A_ST, 32'h1);
      cpu_wr(A_TX, 32'h77);
      rx_byte(8'h99, 3);
      reset = 1'b0;
      #1;
      check("flush_con", uart_con, 0);
      check("flush_txd", uart_txd, 0);
      check("flush_irq", irq, 0);
      tick();
      reset = 1'b1;
      tick();
      cpu_rd(A_ST, d); check("flush_status", d, 32'h4);
      cpu_rd(A_RX, d); check("flush_rx", d, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
